// File: rtl/shift_reg_univ_if.sv
// Bus bundle for shift_reg_univ: mode/burst controls, serial and parallel
// data, and the register/status outputs. The master drives the controls;
// the slave (the shift register) drives q, ser_out_*, busy and done.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [STEP-1:0]  ser_in_l;
    logic [STEP-1:0]  ser_in_r;
    logic [WIDTH-1:0] par_in;
    logic             rot;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic             burst_dir;
    logic [WIDTH-1:0] q;
    logic [STEP-1:0]  ser_out_l;
    logic [STEP-1:0]  ser_out_r;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, ser_in_l, ser_in_r, par_in, rot,
               start, burst_len, burst_dir,
        input  q, ser_out_l, ser_out_r, busy, done
    );

    modport slave (
        input  en, mode, ser_in_l, ser_in_r, par_in, rot,
               start, burst_len, burst_dir,
        output q, ser_out_l, ser_out_r, busy, done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift left / shift right / parallel load,
// STEP bits per shift) with a burst engine that performs a programmed number
// of shifts on its own and reports busy/done.
// Optional feature macro: SHIFT_REG_UNIV_ROTATE_EN -- when defined, rot=1
// turns every shift (mode or burst) into a rotate; otherwise rot is ignored.
// rst is asynchronous and active low; every output comes from a register.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_reg_univ_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [STEP-1:0]  r_ser_out_l;
    logic [STEP-1:0]  r_ser_out_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;

    logic [STEP-1:0]  w_fill_l;
    logic [STEP-1:0]  w_fill_r;
    logic [WIDTH-1:0] w_q_shl;
    logic [WIDTH-1:0] w_q_shr;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    // Rotate recirculates the bits leaving the opposite end instead of the serial inputs.
    assign w_fill_l = bus.rot ? r_q[WIDTH-1 -: STEP] : bus.ser_in_l;
    assign w_fill_r = bus.rot ? r_q[STEP-1:0]        : bus.ser_in_r;
`else
    logic w_unused_rot;
    assign w_unused_rot = bus.rot;
    assign w_fill_l     = bus.ser_in_l;
    assign w_fill_r     = bus.ser_in_r;
`endif

    // Next register value for a left and a right shift; shared by mode ops and bursts.
    assign w_q_shl = {r_q[WIDTH-STEP-1:0], w_fill_l};
    assign w_q_shr = {w_fill_r, r_q[WIDTH-1:STEP]};

    // Control FSM plus data path: mode ops in IDLE, one shift per cycle in SHIFT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_q         <= '0;
            r_ser_out_l <= '0;
            r_ser_out_r <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        // start wins over en/mode; a zero-length burst completes at once
                        if (bus.burst_len != CNT_ZERO) begin
                            r_cnt   <= bus.burst_len;
                            r_dir   <= bus.burst_dir;
                            r_busy  <= 1'b1;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else if (bus.en) begin
                        case (bus.mode)
                            2'b01: begin
                                r_q         <= w_q_shl;
                                r_ser_out_l <= r_q[WIDTH-1 -: STEP];
                            end
                            2'b10: begin
                                r_q         <= w_q_shr;
                                r_ser_out_r <= r_q[STEP-1:0];
                            end
                            2'b11: r_q <= bus.par_in;
                            default: ;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    if (r_dir) begin
                        r_q         <= w_q_shr;
                        r_ser_out_r <= r_q[STEP-1:0];
                    end else begin
                        r_q         <= w_q_shl;
                        r_ser_out_l <= r_q[WIDTH-1 -: STEP];
                    end
                    r_cnt <= r_cnt - CNT_ONE;
                    // The count still holds this cycle's shift, so 1 means last shift.
                    if (r_cnt == CNT_ONE) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.q         = r_q;
    assign bus.ser_out_l = r_ser_out_l;
    assign bus.ser_out_r = r_ser_out_r;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
